// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: instruction-in / decoded-entry-out handshake bundle.
//   in_valid/in_ready/in_instr/in_tag          : producer side (instruction offer)
//   out_valid/out_ready/out_alu_ctrl/...       : consumer side (decoded head entry)
// master: the environment (drives instructions, consumes results).
// slave : the decode stage.
interface alu_decode_stage_if #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_alu_ctrl;
    logic              out_src_imm;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_src_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_src_imm, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes RV32I instruction words into an ALU control code and
// operand-B select, and buffers the results in a DEPTH-entry FIFO.
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   flush        : synchronous discard of every queued entry
//   bus          : alu_decode_stage_if.slave (instruction in, decoded entry out)
//   illegal_cnt  : saturating count of accepted illegal instructions
module alu_decode_stage #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = CTRL_W + 2 + TAG_W;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSlt   = 4'd5,
        AluSltu  = 4'd6,
        AluSll   = 4'd7,
        AluSrl   = 4'd8,
        AluSra   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_alt;
    logic       w_f7_ok;
    alu_op_e    w_op;
    logic       w_imm;
    logic       w_ill;

    assign w_opcode = bus.in_instr[6:0];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_funct7 = bus.in_instr[31:25];
    assign w_alt    = (w_funct7 == 7'b0100000);
    // funct7 is legal if zero, or the alternate encoding on SUB/SRA slots only
    assign w_f7_ok  = (w_funct7 == 7'b0000000) ||
                      (w_alt && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

    always_comb begin
        w_op  = AluAdd;
        w_imm = 1'b0;
        w_ill = 1'b0;
        case (w_opcode)
            OpLoad, OpStore, OpAuipc, OpJalr: w_imm = 1'b1;
            OpJal: w_imm = 1'b0;
            OpBranch: begin
                case (w_funct3)
                    3'b000, 3'b001: w_op = AluSub;
                    3'b100, 3'b101: w_op = AluSlt;
                    3'b110, 3'b111: w_op = AluSltu;
                    default:        w_ill = 1'b1;
                endcase
            end
            OpLui: begin
                w_op  = AluPassB;
                w_imm = 1'b1;
            end
            OpReg, OpImm: begin
                w_imm = (w_opcode == OpImm);
                case (w_funct3)
                    3'b000:  w_op = (!w_imm && w_alt) ? AluSub : AluAdd;
                    3'b001:  w_op = AluSll;
                    3'b010:  w_op = AluSlt;
                    3'b011:  w_op = AluSltu;
                    3'b100:  w_op = AluXor;
                    3'b101:  w_op = w_alt ? AluSra : AluSrl;
                    3'b110:  w_op = AluOr;
                    default: w_op = AluAnd;
                endcase
                // Immediate forms only carry funct7 in the shift encodings
                if ((w_opcode == OpReg) || (w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    if (!w_f7_ok) begin
                        w_ill = 1'b1;
                    end
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_op  = AluAdd;
            w_imm = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               r_active;
    logic [CNT_W-1:0]   r_ill_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_not_full;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_head;

    assign w_not_full   = (r_count < (PTR_W+1)'(DEPTH));
    // r_active holds in_ready low from reset assertion until the first edge after release
    assign bus.in_ready = r_active && w_not_full && !flush;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (r_count != '0);
    assign w_pop        = bus.out_valid && bus.out_ready;
    assign w_wdata      = {CTRL_W'(w_op), w_imm, w_ill, bus.in_tag};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by natural overflow
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (PTR_W+1)'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - (PTR_W+1)'(1);
                end
            end
        end
    end

    // Counts accepted instructions only, so a push discarded by flush never counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_ill && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign illegal_cnt = r_ill_cnt;

    // Head fields are masked so the outputs read zero whenever the queue is empty
    assign w_head           = r_mem[r_rptr];
    assign bus.out_alu_ctrl = bus.out_valid ? w_head[ENTRY_W-1 -: CTRL_W] : '0;
    assign bus.out_src_imm  = bus.out_valid ? w_head[TAG_W+1] : 1'b0;
    assign bus.out_illegal  = bus.out_valid ? w_head[TAG_W] : 1'b0;
    assign bus.out_tag      = bus.out_valid ? w_head[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_alu_decode_stage.sv
`timescale 1ns/1ps
module tb_alu_decode_stage;

    localparam int CTRL_W = 4;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0]       ctrl;
        logic             imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] illegal_cnt;

    alu_decode_stage_if #(.CTRL_W(CTRL_W), .TAG_W(TAG_W)) bus ();

    alu_decode_stage #(
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cnt = 0;
    bit   active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set tables
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] base [8];
        logic [3:0] br [8];
        bit ill;
        base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        br   = '{4'd1, 4'd1, 4'd15, 4'd15, 4'd5, 4'd5, 4'd6, 4'd6};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.tag = tag;
        e.ctrl = 4'd0;
        e.imm = 1'b0;
        ill = 1'b0;
        if (op == 7'h03 || op == 7'h23 || op == 7'h17 || op == 7'h67) begin
            e.imm = 1'b1;
        end else if (op == 7'h6F) begin
            e.imm = 1'b0;
        end else if (op == 7'h63) begin
            if (br[f3] == 4'd15) ill = 1'b1;
            else e.ctrl = br[f3];
        end else if (op == 7'h37) begin
            e.ctrl = 4'd10;
            e.imm = 1'b1;
        end else if (op == 7'h33 || op == 7'h13) begin
            bit is_i;
            is_i = (op == 7'h13);
            e.imm = is_i;
            e.ctrl = base[f3];
            if (is_i && f3 != 3'd1 && f3 != 3'd5) begin
                // funct7 is part of the immediate here
            end else if (f7 == 7'h00) begin
                // base operation
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.ctrl = 4'd9;
            end else if (f7 == 7'h20 && f3 == 3'd0 && !is_i) begin
                e.ctrl = 4'd1;
            end else begin
                ill = 1'b1;
            end
        end else begin
            ill = 1'b1;
        end
        e.ill = ill;
        if (ill) begin
            e.ctrl = 4'd0;
            e.imm = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [31:0] mid;
        int          sel;
        ops = '{7'h03, 7'h23, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h37, 7'h33, 7'h13, 7'h33};
        sel = $urandom_range(0, 11);
        mid = $urandom();
        if (sel < 10) op = ops[sel];
        else op = mid[31:25];
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        return {f7, mid[9:0], 3'($urandom()), mid[14:10], op};
    endfunction

    // Monitor: compare every popped head against the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got tag %0h, expected no entry", bus.out_tag);
            end else begin
                mon_e = q.pop_front();
                check("pop_ctrl", 32'(bus.out_alu_ctrl), 32'(mon_e.ctrl));
                check("pop_imm", 32'(bus.out_src_imm), 32'(mon_e.imm));
                check("pop_ill", 32'(bus.out_illegal), 32'(mon_e.ill));
                check("pop_tag", 32'(bus.out_tag), 32'(mon_e.tag));
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+1
    task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tag,
                        input logic ordy, input logic fl);
        bit exp_rdy;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        exp_rdy = active && (q.size() < DEPTH) && !fl;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
        if (q.size() == 0) begin
            check("idle_zero", {bus.out_alu_ctrl, bus.out_src_imm, bus.out_illegal, bus.out_tag}, 0);
        end
        @(negedge clk);
        if (v && exp_rdy) begin
            exp_t e;
            e = ref_decode(ins, tag);
            q.push_back(e);
            if (e.ill && model_cnt < CNT_MAX) model_cnt++;
        end
        @(posedge clk);
        #1;
        if (fl) q.delete();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, '0, ordy, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_cnt", 32'(illegal_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        active = 1'b1;

        // Single SUB with consumer ready
        step(1'b1, 32'h40B50533, 5'd1, 1'b1, 1'b0);
        check("sub_valid", 32'(bus.out_valid), 1);
        check("sub_ctrl", 32'(bus.out_alu_ctrl), 1);
        check("sub_imm", 32'(bus.out_src_imm), 0);
        check("sub_ill", 32'(bus.out_illegal), 0);
        idle(1'b1);

        // SRAI then XORI with back-pressure, then drain in order
        step(1'b1, 32'h4020D093, 5'd2, 1'b0, 1'b0);
        step(1'b1, 32'h00A5C513, 5'd3, 1'b0, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("srai_ctrl", 32'(bus.out_alu_ctrl), 9);
        check("srai_imm", 32'(bus.out_src_imm), 1);
        step(1'b0, 32'h0, '0, 1'b0, 1'b0);
        check("stall_tag", 32'(bus.out_tag), 2);
        idle(1'b1);
        check("xori_ctrl", 32'(bus.out_alu_ctrl), 4);
        check("xori_imm", 32'(bus.out_src_imm), 1);
        idle(1'b1);

        // Full queue with simultaneous offer and consume
        step(1'b1, 32'h00B50533, 5'd4, 1'b0, 1'b0);
        step(1'b1, 32'h00B50533, 5'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00B57533, 5'(6 + i), 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Illegal encodings
        step(1'b1, 32'h0000007F, 5'd10, 1'b1, 1'b0);
        step(1'b1, 32'h02B50533, 5'd11, 1'b1, 1'b0);
        idle(1'b1);
        check("ill_cnt_2", 32'(illegal_cnt), 2);

        // Flush with a same-cycle (illegal) offer
        step(1'b1, 32'h00B50533, 5'd12, 1'b0, 1'b0);
        step(1'b1, 32'h00B50533, 5'd13, 1'b0, 1'b0);
        step(1'b1, 32'h0000007F, 5'd14, 1'b0, 1'b1);
        check("flush_valid", 32'(bus.out_valid), 0);
        check("flush_cnt", 32'(illegal_cnt), 2);
        idle(1'b1);

        // Saturation
        for (int i = 0; i < 300; i++) step(1'b1, 32'h0000007F, 5'(i), 1'b1, 1'b0);
        idle(1'b1);
        check("ill_sat", 32'(illegal_cnt), 255);

        // Asynchronous reset between edges with one entry queued
        step(1'b1, 32'h00150513, 5'd15, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_ready", 32'(bus.in_ready), 0);
        check("arst_cnt", 32'(illegal_cnt), 0);
        check("arst_tag", 32'(bus.out_tag), 0);
        q.delete();
        model_cnt = 0;
        active = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        active = 1'b1;
        idle(1'b0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), 5'($urandom()),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (4) idle(1'b1);
        check("drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
